// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: register-address width,
// the hardwired zero register and the sequencer state encoding.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// sequencer (slave): hazard inputs, register enables/flushes and status.
interface pipeline_hazard_ctrl_if
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rt;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  mem_branch_taken;
    logic                  mem_jump;
    logic                  mem_req;
    logic                  dmem_ready;

    logic                  pc_en;
    logic                  pc_sel_target;
    logic                  ifid_en;
    logic                  ifid_flush;
    logic                  idex_en;
    logic                  idex_flush;
    logic                  exmem_en;
    logic                  exmem_flush;
    logic                  memwb_bubble;
    logic                  mem_timeout;
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      flush_events;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd,
               mem_branch_taken, mem_jump, mem_req, dmem_ready,
        input  pc_en, pc_sel_target, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, exmem_flush, memwb_bubble, mem_timeout,
               stall_cycles, flush_events
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd,
               mem_branch_taken, mem_jump, mem_req, dmem_ready,
        output pc_en, pc_sel_target, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, exmem_flush, memwb_bubble, mem_timeout,
               stall_cycles, flush_events
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clear_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB registers: resolves
// memory waits, MEM-stage redirects and load-use stalls, with status counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input logic                   clk,
    input logic                   reset,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             mem_hold, redirect, load_use;

    assign mem_hold = bus.mem_req & ~bus.dmem_ready;
    assign redirect = bus.mem_branch_taken | bus.mem_jump;
    assign load_use = bus.ex_mem_read & (bus.ex_rd != ZERO_REG) &
                      ((bus.ex_rd == bus.id_rs) |
                       (bus.id_uses_rt & (bus.ex_rd == bus.id_rt)));

    // Priority is identical in both states; MEM_WAIT only tracks the wait length.
    always_comb begin
        state_d           = ST_RUN;
        bus.pc_en         = 1'b1;
        bus.pc_sel_target = 1'b0;
        bus.ifid_en       = 1'b1;
        bus.ifid_flush    = 1'b0;
        bus.idex_en       = 1'b1;
        bus.idex_flush    = 1'b0;
        bus.exmem_en      = 1'b1;
        bus.exmem_flush   = 1'b0;
        bus.memwb_bubble  = 1'b0;
        if (reset) begin
            state_d = ST_RUN;
        end else if (mem_hold) begin
            state_d          = ST_MEM_WAIT;
            bus.pc_en        = 1'b0;
            bus.ifid_en      = 1'b0;
            bus.idex_en      = 1'b0;
            bus.exmem_en     = 1'b0;
            bus.memwb_bubble = 1'b1;
        end else if (redirect) begin
            bus.pc_sel_target = 1'b1;
            bus.ifid_flush    = 1'b1;
            bus.idex_flush    = 1'b1;
            bus.exmem_flush   = 1'b1;
        end else if (load_use) begin
            bus.pc_en      = 1'b0;
            bus.ifid_en    = 1'b0;
            bus.idex_flush = 1'b1;
        end
    end

    always_comb begin
        timeout_d = timeout_q;
        if (mem_hold && (wait_cnt_q == WAIT_LAST))
            timeout_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RUN;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timeout_q <= timeout_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk     (clk),
        .rst     (reset),
        .inc_i   (mem_hold),
        .clear_i ((state_q == ST_MEM_WAIT) & ~mem_hold),
        .count_o (wait_cnt_q)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (reset),
        .inc_i   (~bus.pc_en),
        .clear_i (1'b0),
        .count_o (bus.stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (reset),
        .inc_i   (redirect & ~mem_hold),
        .clear_i (1'b0),
        .count_o (bus.flush_events)
    );

    assign bus.mem_timeout = timeout_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates per-register enable, flush and bubble controls for three cases:
  - load-use stalls;
  - branch/jump redirects resolved in the MEM stage;
  - multi-cycle data-memory waits.
- Keeps saturating performance counters and a sticky memory-timeout flag.

Parameters:
- CNT_W, 16, width of stall_cycles and flush_events counters.
- MEM_TIMEOUT, 64, number of wait cycles before mem_timeout is asserted (legal range 2..2^CNT_W-1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- ex_mem_read  in  1  MemRead of the instruction in ID/EX.
- ex_rd  in  5  destination register of the instruction in ID/EX.
- mem_branch_taken  in  1  EX/MEM branch_out AND zero_out.
- mem_jump  in  1  EX/MEM jump_out.
- mem_req  in  1  EX/MEM MemRead_out OR MemWrite_out.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC load enable.
- pc_sel_target  out  1  PC loads the branch/jump target.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID clears to NOP.
- idex_en  out  1  ID/EX load enable.
- idex_flush  out  1  ID/EX loads a bubble (all control bits 0).
- exmem_en  out  1  EX/MEM load enable.
- exmem_flush  out  1  EX/MEM loads a bubble.
- memwb_bubble  out  1  MEM/WB captures RegWrite=0.
- mem_timeout  out  1  sticky error flag.
- stall_cycles  out  CNT_W  cycles with pc_en=0.
- flush_events  out  CNT_W  number of redirects.

Behaviour:
- FSM states: RUN, MEM_WAIT. Reset value is RUN.
- Reset values: wait_cnt=0, mem_timeout=0, stall_cycles=0, flush_events=0.
- While reset is high, the outputs take the RUN/no-hazard values: all enables 1, all flush/bubble/pc_sel_target 0.
- Control outputs are combinational from state and inputs (0-cycle latency). Counters and flags update on the clock edge.
- Definitions:
  - mem_hold = mem_req & ~dmem_ready.
  - redirect = mem_branch_taken | mem_jump.
  - load_use = ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs) | (id_uses_rt & ex_rd == id_rt)).
- Priority per cycle, in either state: mem_hold > redirect > load_use > normal.
- mem_hold:
  - pc_en=ifid_en=idex_en=exmem_en=0, memwb_bubble=1.
  - Next state MEM_WAIT.
  - wait_cnt increments. It resets to 0 when leaving MEM_WAIT and is 0 in RUN.
- redirect (and no mem_hold):
  - pc_en=1, pc_sel_target=1, ifid_flush=idex_flush=exmem_flush=1.
  - flush_events += 1, saturating.
- load_use (and no redirect, no mem_hold):
  - pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1.
  - Repeats while the condition holds. It is normally one cycle, because the bubble clears ex_mem_read.
- normal: all enables 1, no flushes.
- MEM_WAIT with dmem_ready=1:
  - This cycle evaluates redirect/load_use/normal exactly as RUN does.
  - Next state RUN.
- MEM_WAIT with mem_req falling to 0: treated as ready, next state RUN.
- Timeout: when wait_cnt == MEM_TIMEOUT-1 and mem_hold, set mem_timeout=1.
  - mem_timeout stays set until reset.
  - The FSM remains in MEM_WAIT; there is no forced recovery.
- stall_cycles increments each cycle pc_en=0 and saturates at all-ones. flush_events saturates likewise.
- Simultaneous redirect and load_use: redirect wins and the instruction in ID is flushed; no stall cycle is counted.
- Reset asserted mid-MEM_WAIT: asynchronous return to RUN; wait_cnt, flag and counters are cleared.

Decomposition:
- Shared pipeline package holds:
  - the state encoding localparams (ST_RUN, ST_MEM_WAIT);
  - REG_ADDR_W=5;
  - the zero-register constant.
- One sub-module, sat_counter (width parameter, inc, clear), instantiated for stall_cycles, flush_events and wait_cnt.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=8, id_rs=8 for one cycle, then ex_mem_read=0 -> exactly one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cycles=1.
- ex_rd=0 with ex_mem_read=1, id_rs=0 -> no stall (pc_en=1); id_uses_rt=0 with ex_rd==id_rt=9 -> no stall.
- Taken branch: mem_branch_taken=1 for 1 cycle -> pc_sel_target=1, ifid/idex/exmem_flush=1 that cycle; flush_events=1.
- Memory wait: mem_req=1, dmem_ready=0 for 3 cycles then 1 -> 3 cycles of all enables 0 and memwb_bubble=1, state returns to RUN; stall_cycles=3.
- Wait plus redirect: mem_req=1, mem_jump=1, dmem_ready low 2 cycles then high -> freeze 2 cycles, then a redirect on the ready cycle; flush_events=1.
- Timeout and reset: MEM_TIMEOUT=4, dmem_ready held 0 -> mem_timeout=1 after the 4th wait cycle and stays 1; assert reset mid-wait -> state RUN, all counters 0, mem_timeout=0 asynchronously.
